// File: rtl/share_unpack_pkg.sv
// Shared sizing for the share path. It holds the per-parameter-set constants and
// the byte/word count derivations, so that commit and share_unpack size identically.
package share_unpack_pkg;

    localparam int unsigned LAMBDA_L1  = 128;
    localparam int unsigned WEIGHT_L1  = 79;
    localparam int unsigned D_SPLIT_L1 = 1;
    localparam int unsigned K_L1       = 126;
    localparam int unsigned T_L1       = 3;
    localparam int unsigned ETA_L1     = 4;

    localparam int unsigned LAMBDA_L3  = 192;
    localparam int unsigned WEIGHT_L3  = 120;
    localparam int unsigned D_SPLIT_L3 = 2;
    localparam int unsigned K_L3       = 193;
    localparam int unsigned T_L3       = 3;
    localparam int unsigned ETA_L3     = 4;

    localparam int unsigned LAMBDA_L5  = 256;
    localparam int unsigned WEIGHT_L5  = 150;
    localparam int unsigned D_SPLIT_L5 = 2;
    localparam int unsigned K_L5       = 278;
    localparam int unsigned T_L5       = 3;
    localparam int unsigned ETA_L5     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Valid share bytes: K + 2*WEIGHT + T*(2*D_SPLIT+1)*ETA.
    function automatic int unsigned calc_n_bytes(input logic [15:0] ps);
        int unsigned n;
        case (ps)
            "L3":    n = K_L3 + 2 * WEIGHT_L3 + T_L3 * (2 * D_SPLIT_L3 + 1) * ETA_L3;
            "L5":    n = K_L5 + 2 * WEIGHT_L5 + T_L5 * (2 * D_SPLIT_L5 + 1) * ETA_L5;
            default: n = K_L1 + 2 * WEIGHT_L1 + T_L1 * (2 * D_SPLIT_L1 + 1) * ETA_L1;
        endcase
        return n;
    endfunction

    // Share-memory words needed to hold n_bytes.
    function automatic int unsigned calc_depth(input int unsigned n_bytes, input int unsigned width);
        return (8 * n_bytes + width - 1) / width;
    endfunction

    // Address width, kept at least 1 bit for a single-word memory.
    function automatic int unsigned calc_aw(input int unsigned depth);
        return (depth > 1) ? int'($clog2(depth)) : 1;
    endfunction

endpackage

// File: rtl/share_unpack_if.sv
// Share-memory read port plus byte stream.
// master: the unpacker (drives address/strobe and the byte stream).
// slave : memory + consumer (return read data and ready).
interface share_unpack_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = 6
);
    logic [AW-1:0]    o_mem_addr;
    logic             o_mem_rd_en;
    logic [WIDTH-1:0] i_mem_q;
    logic [7:0]       o_byte;
    logic             o_byte_valid;
    logic             i_byte_ready;
    logic             o_last;

    modport master (
        output o_mem_addr, o_mem_rd_en, o_byte, o_byte_valid, o_last,
        input  i_mem_q, i_byte_ready
    );

    modport slave (
        input  o_mem_addr, o_mem_rd_en, o_byte, o_byte_valid, o_last,
        output i_mem_q, i_byte_ready
    );
endinterface

// File: rtl/share_word_prefetch.sv
// One-word prefetch buffer. It holds the read-address counter, nxt_word and nxt_valid.
// Ports: i_clear restarts at address 1 (address 0 goes straight to the shifter);
//        i_issue takes a read at o_rd_addr; i_consume releases nxt_word;
//        o_more_c indicates that words remain to be read.
module share_word_prefetch #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 40,
    parameter int unsigned AW    = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_issue,
    input  logic             i_consume,
    input  logic [WIDTH-1:0] i_mem_q,
    output logic [AW-1:0]    o_rd_addr,
    output logic             o_more_c,
    output logic [WIDTH-1:0] o_nxt_word,
    output logic             o_nxt_valid
);
    localparam int unsigned RAW = $clog2(DEPTH + 1);

    logic [RAW-1:0]   rd_addr_q;
    logic             pending_q;
    logic [WIDTH-1:0] nxt_word_q;
    logic             nxt_valid_q;

    // Data for a read issued last cycle is on i_mem_q now.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_addr_q   <= '0;
            pending_q   <= 1'b0;
            nxt_word_q  <= '0;
            nxt_valid_q <= 1'b0;
        end else begin
            pending_q <= i_issue && !i_clear;
            if (i_clear) begin
                rd_addr_q   <= RAW'(1);
                nxt_valid_q <= 1'b0;
            end else begin
                if (i_issue) begin
                    rd_addr_q <= rd_addr_q + RAW'(1);
                end
                if (pending_q) begin
                    nxt_word_q  <= i_mem_q;
                    nxt_valid_q <= 1'b1;
                end else if (i_consume) begin
                    nxt_valid_q <= 1'b0;
                end
            end
        end
    end

    assign o_rd_addr   = rd_addr_q[AW-1:0];
    assign o_more_c    = (rd_addr_q < RAW'(DEPTH));
    assign o_nxt_word  = nxt_word_q;
    assign o_nxt_valid = nxt_valid_q;
endmodule

// File: rtl/share_unpack.sv
// Share unpacker. It streams N_BYTES share bytes, MSB first, out of a WIDTH-bit
// share memory with one-cycle read latency.
// Ports: i_clk/i_rst_n (async active-low), i_start pulse, o_busy (PRIME/RUN),
//        o_done (DONE), and bus (the memory read port and the valid/ready byte stream).
// The memory request (o_mem_rd_en/o_mem_addr) is decoded combinationally from
// registered state. A read therefore lands in the cycle after it is issued.
module share_unpack
    import share_unpack_pkg::*;
#(
    parameter logic [15:0] PARAMETER_SET = "L1",
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned N_BYTES       = calc_n_bytes(PARAMETER_SET),
    parameter int unsigned DEPTH         = calc_depth(N_BYTES, WIDTH)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    output logic            o_busy,
    output logic            o_done,
    share_unpack_if.master  bus
);
    localparam int unsigned BPW = WIDTH / 8;
    localparam int unsigned BW  = $clog2(BPW);
    localparam int unsigned CW  = $clog2(N_BYTES + 1);
    localparam int unsigned AW  = calc_aw(DEPTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [BW-1:0]    bin_q, bin_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             valid_q, valid_d, last_q, last_d;

    logic             start_go_c, issue_c, consume_c, xfer_c;
    logic [AW-1:0]    pf_rd_addr;
    logic             pf_more_c, pf_nxt_valid;
    logic [WIDTH-1:0] pf_nxt_word;

    share_word_prefetch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_prefetch (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (start_go_c),
        .i_issue    (issue_c),
        .i_consume  (consume_c),
        .i_mem_q    (bus.i_mem_q),
        .o_rd_addr  (pf_rd_addr),
        .o_more_c   (pf_more_c),
        .o_nxt_word (pf_nxt_word),
        .o_nxt_valid(pf_nxt_valid)
    );

    assign xfer_c = valid_q && bus.i_byte_ready;

    // Next state, byte shifter and read requests.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        bin_d      = bin_q;
        cnt_d      = cnt_q;
        empty_d    = empty_q;
        start_go_c = 1'b0;
        issue_c    = 1'b0;
        consume_c  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start && i_rst_n) begin
                    start_go_c = 1'b1;
                    cnt_d      = '0;
                    bin_d      = '0;
                    empty_d    = 1'b0;
                    state_d    = ST_PRIME;
                end
            end
            ST_PRIME: begin
                cur_d   = bus.i_mem_q;
                bin_d   = '0;
                issue_c = pf_more_c;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (xfer_c) begin
                    cnt_d = cnt_q + CW'(1);
                    cur_d = cur_q << 8;
                    if (cnt_q == CW'(N_BYTES - 1)) begin
                        state_d = ST_DONE;
                    end else if (bin_q == BW'(BPW - 1)) begin
                        bin_d = '0;
                        if (pf_nxt_valid) begin
                            cur_d     = pf_nxt_word;
                            consume_c = 1'b1;
                            issue_c   = pf_more_c;
                        end else begin
                            empty_d = 1'b1;
                        end
                    end else begin
                        bin_d = bin_q + BW'(1);
                    end
                end else if (empty_q && pf_nxt_valid) begin
                    // Late word arrived after the shifter drained.
                    cur_d     = pf_nxt_word;
                    empty_d   = 1'b0;
                    consume_c = 1'b1;
                    issue_c   = pf_more_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d == ST_PRIME) || (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
        valid_d = (state_d == ST_RUN) && !empty_d;
        last_d  = valid_d && (cnt_d == CW'(N_BYTES - 1));
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign bus.o_byte       = cur_q[WIDTH-1 -: 8];
    assign bus.o_byte_valid = valid_q;
    assign bus.o_last       = last_q;
    assign bus.o_mem_rd_en  = start_go_c || issue_c;
    assign bus.o_mem_addr   = issue_c ? pf_rd_addr : '0;
endmodule

// File: tb/tb_share_unpack.sv
// Bench for share_unpack: L1 and L3 instances share clock, reset, start and ready.
// Each lane keeps a stream model: the expected byte array, the run phase and the
// expected read order. The lane is checked every cycle at the falling edge.
module tb_share_unpack;
    import share_unpack_pkg::*;

    localparam int unsigned W = 64;
    localparam int P_IDLE = 0, P_DONE = 1, P_PRIME = 2, P_RUN = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;
    int   rdy_pct = 100;
    int   errors = 0;
    int   checks = 0;

    int         m_phase[2] = '{P_IDLE, P_IDLE};
    int         m_idx[2]   = '{0, 0};
    int         m_reads[2] = '{0, 0};
    int         m_vcyc[2]  = '{0, 0};
    logic [7:0] m_last_byte[2];
    logic [7:0] m_b64[2];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam logic [15:0] PS = (g == 0) ? "L1" : "L3";
        localparam int unsigned N  = calc_n_bytes(PS);
        localparam int unsigned D  = calc_depth(N, W);
        localparam int unsigned AW = calc_aw(D);

        logic       busy, done;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_byte = 8'h00;
        int         rd_next = 0;
        logic [7:0] exp_b [D*W/8];
        logic [W-1:0] mem [D];

        share_unpack_if #(.WIDTH(W), .AW(AW)) bus ();

        share_unpack #(.PARAMETER_SET(PS), .WIDTH(W)) u_dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .i_start(start),
            .o_busy (busy),
            .o_done (done),
            .bus    (bus)
        );

        // L1 carries the 0x00..0x3F pattern; L3 carries random bytes, including the pad.
        initial begin
            for (int j = 0; j < int'(D * W / 8); j++)
                exp_b[j] = (g == 0) ? 8'(j & 63) : 8'($urandom);
            for (int k = 0; k < int'(D); k++)
                for (int i = 0; i < int'(W / 8); i++)
                    mem[k][W-1-8*i -: 8] = exp_b[k*(W/8)+i];
        end

        assign bus.i_byte_ready = ready;
        always @(posedge clk) if (bus.o_mem_rd_en) bus.i_mem_q <= mem[bus.o_mem_addr];

        always @(negedge clk) begin
            if (!rst_n) begin
                chk($sformatf("L%0d_rst_ctrl", g),
                    64'({busy, done, bus.o_byte_valid, bus.o_last, bus.o_mem_rd_en}), 64'd0);
                chk($sformatf("L%0d_rst_data", g), 64'({bus.o_mem_addr, bus.o_byte}), 64'd0);
                m_phase[g] = P_IDLE;
                m_idx[g]   = 0;
                prev_stall = 1'b0;
            end else if (m_phase[g] == P_IDLE || m_phase[g] == P_DONE) begin
                chk($sformatf("L%0d_idle_busy", g), 64'(busy), 64'd0);
                chk($sformatf("L%0d_idle_done", g), 64'(done), 64'(m_phase[g] == P_DONE));
                chk($sformatf("L%0d_idle_valid", g), 64'(bus.o_byte_valid), 64'd0);
                if (start) begin
                    chk($sformatf("L%0d_start_rd_en", g), 64'(bus.o_mem_rd_en), 64'd1);
                    chk($sformatf("L%0d_start_addr", g), 64'(bus.o_mem_addr), 64'd0);
                    m_phase[g] = P_PRIME;
                    m_idx[g]   = 0;
                    m_reads[g] = 1;
                    m_vcyc[g]  = 0;
                    rd_next    = 1;
                    prev_stall = 1'b0;
                end else begin
                    chk($sformatf("L%0d_idle_rd_en", g), 64'(bus.o_mem_rd_en), 64'd0);
                end
            end else begin
                chk($sformatf("L%0d_run_busy", g), 64'(busy), 64'd1);
                chk($sformatf("L%0d_run_done", g), 64'(done), 64'd0);
                if (bus.o_mem_rd_en) begin
                    chk($sformatf("L%0d_rd_addr", g), 64'(bus.o_mem_addr), 64'(rd_next));
                    chk($sformatf("L%0d_rd_in_range", g), 64'(rd_next < int'(D)), 64'd1);
                    rd_next++;
                    m_reads[g]++;
                end
                if (m_phase[g] == P_PRIME) begin
                    chk($sformatf("L%0d_prime_valid", g), 64'(bus.o_byte_valid), 64'd0);
                    m_phase[g] = P_RUN;
                end else begin
                    if (rdy_pct == 100)
                        chk($sformatf("L%0d_throughput", g), 64'(bus.o_byte_valid), 64'd1);
                    if (prev_stall) begin
                        chk($sformatf("L%0d_stall_valid", g), 64'(bus.o_byte_valid), 64'd1);
                        chk($sformatf("L%0d_stall_byte", g), 64'(bus.o_byte), 64'(prev_byte));
                    end
                    if (bus.o_byte_valid) begin
                        chk($sformatf("L%0d_byte%0d", g, m_idx[g]), 64'(bus.o_byte), 64'(exp_b[m_idx[g]]));
                        chk($sformatf("L%0d_last%0d", g, m_idx[g]), 64'(bus.o_last),
                            64'(m_idx[g] == int'(N) - 1));
                        m_vcyc[g]++;
                        if (m_idx[g] == 64) m_b64[g] = bus.o_byte;
                        if (ready) begin
                            m_last_byte[g] = bus.o_byte;
                            m_idx[g]++;
                            if (m_idx[g] == int'(N)) begin
                                m_phase[g] = P_DONE;
                                chk($sformatf("L%0d_read_count", g), 64'(m_reads[g]), 64'(D));
                            end
                        end
                    end
                    prev_stall = bus.o_byte_valid && !ready;
                    prev_byte  = bus.o_byte;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        ready = ($urandom_range(99) < 32'(rdy_pct));
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(m_phase[0] == P_DONE && m_phase[1] == P_DONE) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk(name, 64'(m_phase[0] == P_DONE && m_phase[1] == P_DONE), 64'd1);
    endtask

    initial begin
        int n;
        cycles(3);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycles(2);

        // Full-speed run.
        rdy_pct = 100;
        pulse_start();
        wait_done("run1_done");
        chk("L1_valid_cycles", 64'(m_vcyc[0]), 64'd320);
        chk("L1_last_byte", 64'(m_last_byte[0]), 64'h3F);
        chk("L1_byte64", 64'(m_b64[0]), 64'h00);
        chk("L1_reads", 64'(m_reads[0]), 64'd40);
        chk("L3_bytes", 64'(m_idx[1]), 64'd493);
        chk("L3_reads", 64'(m_reads[1]), 64'd62);
        cycles(3);

        // Start from DONE under 30% backpressure; a stray start mid-run.
        rdy_pct = 30;
        pulse_start();
        cycles(60);
        pulse_start();
        wait_done("run2_done");
        chk("L1_run2_bytes", 64'(m_idx[0]), 64'd320);
        chk("L1_run2_last_byte", 64'(m_last_byte[0]), 64'h3F);
        chk("L3_run2_reads", 64'(m_reads[1]), 64'd62);

        // Abort by reset after byte 100, then replay from byte 0.
        rdy_pct = 50;
        pulse_start();
        n = 0;
        while (m_idx[0] < 101 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("reset_point_reached", 64'(m_idx[0] >= 101), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        cycles(2);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycles(4);
        rdy_pct = 70;
        pulse_start();
        wait_done("run4_done");
        chk("L1_replay_bytes", 64'(m_idx[0]), 64'd320);
        chk("L3_replay_bytes", 64'(m_idx[1]), 64'd493);
        cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/share_unpack.md
SHARE_UNPACK -- requirements
Module: share_unpack

Interface
REQ-001 Parameter PARAMETER_SET, default "L1"; selects L1/L3/L5 sizing.
REQ-002 Parameter WIDTH, default 64; share-memory word width in bits, multiple of 8, at least 16.
REQ-003 Parameter N_BYTES, default K + 2*WEIGHT + T*(2*D_SPLIT+1)*ETA for PARAMETER_SET (L1: 320); number of valid share bytes.
REQ-004 Parameter DEPTH, default ceil(8*N_BYTES/WIDTH) (L1: 40); number of share-memory words.
REQ-005 i_clk  in  1  single clock; all logic on its rising edge.
REQ-006 i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_start  in  1  one-cycle start pulse; sampled only in IDLE or DONE.
REQ-008 o_busy  out  1  high in PRIME and RUN.
REQ-009 o_done  out  1  high while in DONE.
REQ-010 o_mem_addr  out  clog2(DEPTH)  share-memory read address.
REQ-011 o_mem_rd_en  out  1  read strobe; data returns on i_mem_q exactly one cycle later.
REQ-012 i_mem_q  in  WIDTH  share-memory read data.
REQ-013 o_byte  out  8  current share byte.
REQ-014 o_byte_valid  out  1  o_byte is valid.
REQ-015 i_byte_ready  in  1  consumer accepts; a transfer occurs when o_byte_valid and i_byte_ready are both high.
REQ-016 o_last  out  1  high with o_byte_valid on byte index N_BYTES-1.

Function
REQ-017 FSM states: IDLE, PRIME, RUN, DONE.
REQ-018 IDLE or DONE with i_start high: drive o_mem_rd_en=1 and o_mem_addr=0, clear counters, go to PRIME.
REQ-019 PRIME lasts 1 cycle: capture i_mem_q into cur_word and set byte_in_word=0; if DEPTH>1, issue a read of address 1; go to RUN.
REQ-020 RUN: o_byte = cur_word[WIDTH-1:WIDTH-8], so bytes are emitted MSB first; o_byte_valid=1 unless the next word is pending (REQ-023).
REQ-021 On each transfer: shift cur_word left by 8, increment byte_cnt and byte_in_word.
REQ-022 A read issued at cycle t is captured into nxt_word at t+1 with nxt_valid=1.
REQ-023 Word switch, on a transfer with byte_in_word==WIDTH/8-1:
- If nxt_valid: load cur_word from nxt_word, clear nxt_valid, set byte_in_word=0, and issue a read of the next address if it is below DEPTH.
- If the word is not yet available: hold o_byte_valid low until it is.
REQ-024 Sustained throughput is 1 byte/cycle while i_byte_ready is held high. The first o_byte_valid appears 2 cycles after i_start.
REQ-025 o_byte, o_byte_valid and o_last stay stable while o_byte_valid=1 and i_byte_ready=0.
REQ-026 Transfer of byte N_BYTES-1 (o_last=1) goes to DONE. Trailing pad bytes of word DEPTH-1 are never emitted, and no read beyond DEPTH-1 is issued.
REQ-027 In DONE: o_done=1 and o_byte_valid=0; hold until i_start.
REQ-028 i_start during PRIME or RUN is ignored.
REQ-029 o_mem_rd_en is asserted at most once per address per run; reads are issued in ascending address order.

Reset
REQ-030 While i_rst_n=0, asynchronously: state=IDLE, o_busy=0, o_done=0, o_byte_valid=0, o_last=0, o_mem_rd_en=0, o_mem_addr=0, o_byte=0, nxt_valid=0, all counters=0.
REQ-031 Reset asserted mid-run aborts the run. After release, no output activity occurs until a new i_start.

Structure
REQ-032 A shared package holds the parameter-set constants LAMBDA, WEIGHT, D_SPLIT, K, T and ETA, plus the N_BYTES and DEPTH derivation functions, so commit and share_unpack size identically.
REQ-033 One sub-module, share_word_prefetch, holds nxt_word, nxt_valid and the read-address counter. The FSM and byte shifter stay in share_unpack.

Verification
REQ-034 L1, memory word k = {8 bytes 8k..8k+7}, i_byte_ready=1: 320 bytes 0x00..0x3F repeating in order, 320 consecutive valid cycles, o_last on byte 319, 40 reads.
REQ-035 L3 (N_BYTES=493, DEPTH=62): exactly 493 bytes emitted, the 3 pad bytes of word 61 dropped, no read at address 62.
REQ-036 Random i_byte_ready backpressure at 30% high: byte sequence identical to REQ-034, with no change of o_byte while stalled.
REQ-037 i_rst_n pulled low after byte 100: all outputs 0 within the reset cycle; a new i_start replays from byte 0.
REQ-038 i_start pulsed during RUN: ignored, sequence unchanged. i_start in DONE: a second full run.
